// File: rtl/keyed_secded_pkg.sv
// Shared types and Hamming helpers for the keyed SEC-DED decoder.
// Positions are 1-based Hamming positions; position 0 is the overall parity.
package keyed_secded_pkg;

   typedef enum logic [1:0] {LOCKED, LOAD, ACTIVE, DRAIN} state_t;

   typedef struct packed {
      logic       vld;
      logic [6:0] idx;
   } syn_idx_t;

   // Hamming r plus one overall parity bit.
   function automatic int chk_bits(input int dw);
      int r;
      r = 0;
      for (int k = 15; k >= 1; k--)
         if ((1 << k) >= dw + k + 1) r = k;
      return r + 1;
   endfunction

   // Data bit i sits at the i-th non-power-of-two position.
   function automatic int hamming_pos(input int i);
      int n;
      int p;
      n = 0;
      p = 0;
      for (int q = 3; q < 128; q++) begin
         if ((q & (q - 1)) != 0) begin
            if (n == i) p = q;
            n++;
         end
      end
      return p;
   endfunction

   // Data bits covered by syndrome bit j.
   function automatic logic [63:0] syn_mask(input int j, input int dw);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 64; i++)
         if (i < dw && ((hamming_pos(i) >> j) & 1) != 0) m[i] = 1'b1;
      return m;
   endfunction

   // Syndrome to data index; vld=0 for 0, check-bit or out-of-range positions.
   function automatic syn_idx_t syn2idx(input logic [7:0] syn, input int dw);
      syn_idx_t res;
      res = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < dw && hamming_pos(i) == int'(syn)) begin
            res.vld = 1'b1;
            res.idx = 7'(i);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/keyed_secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of one codeword.
// Ports: i_data/i_chk codeword in; o_syn Hamming syndrome; o_parity overall.
module secded_syndrome
   import keyed_secded_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CHK_W  = chk_bits(DATA_W)
) (
   input  logic [DATA_W-1:0] i_data,
   input  logic [CHK_W-1:0]  i_chk,
   output logic [CHK_W-2:0]  o_syn,
   output logic              o_parity
);

   localparam int R = CHK_W - 1;

   for (genvar j = 0; j < R; j++) begin : g_syn
      localparam logic [DATA_W-1:0] M = DATA_W'(syn_mask(j, DATA_W));
      assign o_syn[j] = (^(i_data & M)) ^ i_chk[j];
   end

   assign o_parity = ^{i_chk, i_data};

endmodule

// File: rtl/keyed_secded_decoder.sv
// Key-locked, 2-stage pipelined SEC-DED decoder with serial key load.
// Ports: key_* serial key load; in_* codeword in; out_* result; *_cnt errors.
module keyed_secded_decoder
   import keyed_secded_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CHK_W  = chk_bits(DATA_W),
   parameter int KEY_W  = DATA_W + CHK_W,
   parameter logic [KEY_W-1:0] LOCK_MASK = 39'h4D_2B3C_9E17,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_start,
   input  logic              key_bit,
   input  logic              key_valid,
   output logic              key_loaded,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CHK_W-1:0]  in_chk,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CHK_W-2:0]  out_syndrome,
   output logic              out_single,
   output logic              out_double,
   output logic [CNT_W-1:0]  single_cnt,
   output logic [CNT_W-1:0]  double_cnt
);

   localparam int R    = CHK_W - 1;
   localparam int KC_W = $clog2(KEY_W + 1);

   state_t            r_state;
   logic [KEY_W-1:0]  r_key;
   logic [KC_W-1:0]   r_kcnt;
   logic              r_key_loaded;

   logic              r_v1;
   logic [DATA_W-1:0] r_d1;
   logic [R-1:0]      r_syn1;
   logic              r_par1;
   logic              r_v2;

   logic [KEY_W-1:0]  w_cw;
   logic [R-1:0]      w_syn;
   logic              w_par;
   logic              w_s2_free;
   logic              w_in_fire;
   logic              w_adv1;
   logic              w_out_fire;
   syn_idx_t          w_sidx;
   logic              w_dbl;
   logic [DATA_W-1:0] w_fix;

   assign w_cw       = {in_chk, in_data} ^ r_key ^ LOCK_MASK;
   assign w_s2_free  = !r_v2 || out_ready;
   assign w_adv1     = r_v1 && w_s2_free;
   assign w_out_fire = r_v2 && out_ready;
   // key_start blocks acceptance in the same cycle it leaves ACTIVE.
   assign in_ready   = (r_state == ACTIVE) && !key_start
                       && (!r_v1 || w_s2_free);
   assign w_in_fire  = in_valid && in_ready;
   assign out_valid  = r_v2;
   assign key_loaded = r_key_loaded;

   secded_syndrome #(
      .DATA_W (DATA_W),
      .CHK_W  (CHK_W)
   ) u_syn (
      .i_data   (w_cw[DATA_W-1:0]),
      .i_chk    (w_cw[KEY_W-1:DATA_W]),
      .o_syn    (w_syn),
      .o_parity (w_par)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= LOCKED;
         r_key        <= '0;
         r_kcnt       <= '0;
         r_key_loaded <= 1'b0;
      end else begin
         unique case (r_state)
            LOCKED: begin
               if (key_start) begin
                  r_state <= LOAD;
                  r_kcnt  <= '0;
               end
            end
            LOAD: begin
               if (key_start) begin
                  r_kcnt <= '0;
               end else if (key_valid) begin
                  r_key <= {r_key[KEY_W-2:0], key_bit};
                  if (r_kcnt == KC_W'(KEY_W - 1)) begin
                     r_state      <= ACTIVE;
                     r_key_loaded <= 1'b1;
                     r_kcnt       <= '0;
                  end else begin
                     r_kcnt <= r_kcnt + KC_W'(1);
                  end
               end
            end
            ACTIVE: begin
               if (key_start) begin
                  r_state      <= DRAIN;
                  r_key_loaded <= 1'b0;
               end
            end
            DRAIN: begin
               if (!r_v1 && !r_v2) begin
                  r_state <= LOAD;
                  r_kcnt  <= '0;
               end
            end
            default: r_state <= LOCKED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1   <= 1'b0;
         r_d1   <= '0;
         r_syn1 <= '0;
         r_par1 <= 1'b0;
      end else if (w_in_fire) begin
         r_v1   <= 1'b1;
         r_d1   <= w_cw[DATA_W-1:0];
         r_syn1 <= w_syn;
         r_par1 <= w_par;
      end else if (w_adv1) begin
         r_v1 <= 1'b0;
      end
   end

   // Odd parity means a single error; only data positions get flipped.
   always_comb begin
      w_sidx = syn2idx(8'(r_syn1), DATA_W);
      w_dbl  = !r_par1 && (r_syn1 != '0);
      w_fix  = r_d1;
      if (r_par1 && w_sidx.vld)
         w_fix = r_d1 ^ (DATA_W'(1) << w_sidx.idx);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v2         <= 1'b0;
         out_data     <= '0;
         out_syndrome <= '0;
         out_single   <= 1'b0;
         out_double   <= 1'b0;
         single_cnt   <= '0;
         double_cnt   <= '0;
      end else begin
         if (w_adv1) begin
            r_v2         <= 1'b1;
            out_data     <= w_fix;
            out_syndrome <= r_syn1;
            out_single   <= r_par1;
            out_double   <= w_dbl;
         end else if (w_out_fire) begin
            r_v2 <= 1'b0;
         end
         if (w_out_fire && out_single && single_cnt != '1)
            single_cnt <= single_cnt + CNT_W'(1);
         if (w_out_fire && out_double && double_cnt != '1)
            double_cnt <= double_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_keyed_secded_decoder.sv
// Self-checking bench for keyed_secded_decoder.
// Reference model works on codeword positions, not on the RTL's structure.
module tb_keyed_secded_decoder;

   localparam int DW = 32;
   localparam int CW = 7;
   localparam int KW = 39;
   localparam int NW = 16;
   localparam logic [KW-1:0] MASK = 39'h4D_2B3C_9E17;

   logic          clk;
   logic          rst_n;
   logic          key_start;
   logic          key_bit;
   logic          key_valid;
   logic          key_loaded;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_chk;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-2:0] out_syndrome;
   logic          out_single;
   logic          out_double;
   logic [NW-1:0] single_cnt;
   logic [NW-1:0] double_cnt;

   keyed_secded_decoder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_start    (key_start),
      .key_bit      (key_bit),
      .key_valid    (key_valid),
      .key_loaded   (key_loaded),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_chk       (in_chk),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_syndrome (out_syndrome),
      .out_single   (out_single),
      .out_double   (out_double),
      .single_cnt   (single_cnt),
      .double_cnt   (double_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [DW-1:0] d;
      logic [5:0]    s;
      logic          sg;
      logic          db;
   } exp_t;

   exp_t          q[$];
   exp_t          m_e;
   logic [KW-1:0] tb_key;
   int            m_single;
   int            m_double;
   int            n_out;

   // Position of data bit i: i-th integer >= 3 that is not a power of two.
   function automatic int dpos(input int i);
      int p;
      int n;
      p = 2;
      n = -1;
      while (n < i) begin
         p++;
         if ((p & (p - 1)) != 0) n++;
      end
      return p;
   endfunction

   function automatic logic [CW-1:0] enc(input logic [DW-1:0] d);
      int x;
      logic [CW-1:0] c;
      x = 0;
      for (int i = 0; i < DW; i++) if (d[i]) x ^= dpos(i);
      c[5:0] = 6'(x);
      c[6]   = ^{d, c[5:0]};
      return c;
   endfunction

   // Syndrome = XOR of the positions of all set bits; parity = popcount odd.
   function automatic exp_t model(input logic [DW-1:0] d,
                                  input logic [CW-1:0] c,
                                  input logic [KW-1:0] k);
      exp_t e;
      logic [KW-1:0] cw;
      int syn;
      int par;
      int p;
      cw = {c, d} ^ k ^ MASK;
      syn = 0;
      par = 0;
      for (int b = 0; b < KW; b++) begin
         if (cw[b]) begin
            if (b < DW) p = dpos(b);
            else if (b < KW - 1) p = 1 << (b - DW);
            else p = 0;
            syn ^= p;
            par ^= 1;
         end
      end
      e.d  = cw[DW-1:0];
      e.s  = 6'(syn);
      e.sg = (par == 1);
      e.db = (par == 0) && (syn != 0);
      if (e.sg)
         for (int i = 0; i < DW; i++)
            if (dpos(i) == syn) e.d[i] = ~e.d[i];
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         m_single = 0;
         m_double = 0;
      end else begin
         chk("single_cnt", 64'(single_cnt), 64'(m_single));
         chk("double_cnt", 64'(double_cnt), 64'(m_double));
         chk("spurious_out", 64'(out_valid && q.size() == 0), 0);
         if (out_valid && q.size() > 0) begin
            m_e = q[0];
            chk("out_data", 64'(out_data), 64'(m_e.d));
            chk("out_syndrome", 64'(out_syndrome), 64'(m_e.s));
            chk("out_single", 64'(out_single), 64'(m_e.sg));
            chk("out_double", 64'(out_double), 64'(m_e.db));
            if (out_ready) begin
               void'(q.pop_front());
               n_out++;
               if (m_e.sg && m_single < 65535) m_single++;
               if (m_e.db && m_double < 65535) m_double++;
            end
         end
         if (in_valid && in_ready)
            q.push_back(model(in_data, in_chk, tb_key));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_chk   = c;
      @(negedge clk);
      while (!in_ready && n < 30) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) chk("send_timeout", 64'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic load_key(input logic [KW-1:0] k);
      key_start = 1'b1;
      tick();
      key_start = 1'b0;
      repeat (5) tick();
      key_start = 1'b1;
      tick();
      key_start = 1'b0;
      for (int i = KW - 1; i >= 0; i--) begin
         key_valid = 1'b1;
         key_bit   = k[i];
         if (i == 0) begin
            @(negedge clk);
            chk("key_loaded_before", 64'(key_loaded), 0);
            chk("in_ready_load", 64'(in_ready), 0);
         end
         tick();
      end
      key_valid = 1'b0;
      tb_key    = k;
      @(negedge clk);
      chk("key_loaded_after", 64'(key_loaded), 1);
      chk("in_ready_active", 64'(in_ready), 1);
      tick();
   endtask

   task automatic wait2();
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 60) begin
         n++;
         tick();
      end
      chk(name, 64'(q.size()), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] d;
      logic [CW-1:0] c;
      int base;
      rst_n     = 1'b1;
      key_start = 1'b0;
      key_bit   = 1'b0;
      key_valid = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_chk    = '0;
      out_ready = 1'b1;
      tb_key    = '0;
      m_single  = 0;
      m_double  = 0;
      n_out     = 0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_key_loaded", 64'(key_loaded), 0);
      chk("rst_in_ready", 64'(in_ready), 0);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_out_data", 64'(out_data), 0);
      chk("rst_single_cnt", 64'(single_cnt), 0);
      chk("rst_double_cnt", 64'(double_cnt), 0);
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      tick();

      load_key(MASK);

      send(32'hDEADBEEF, enc(32'hDEADBEEF));
      @(negedge clk);
      chk("lat_c1_valid", 64'(out_valid), 0);
      @(negedge clk);
      chk("lat_c2_valid", 64'(out_valid), 1);
      chk("clean_data", 64'(out_data), 64'h0DEADBEEF);
      chk("clean_single", 64'(out_single), 0);
      chk("clean_double", 64'(out_double), 0);
      tick();

      send(32'hDEADBEEF ^ 32'h20, enc(32'hDEADBEEF));
      wait2();
      chk("sec_single", 64'(out_single), 1);
      chk("sec_syndrome", 64'(out_syndrome), 64'h0A);
      chk("sec_data", 64'(out_data), 64'h0DEADBEEF);
      @(negedge clk);
      chk("sec_cnt", 64'(single_cnt), 1);
      tick();

      send(32'hDEADBEEF ^ 32'h0002_0020, enc(32'hDEADBEEF));
      wait2();
      chk("ded_double", 64'(out_double), 1);
      chk("ded_syndrome", 64'(out_syndrome), 64'h1D);
      chk("ded_data", 64'(out_data), 64'h0DEAFBECF);
      @(negedge clk);
      chk("ded_cnt", 64'(double_cnt), 1);
      tick();

      load_key(MASK ^ 39'h1);
      send(32'hDEADBEEF, enc(32'hDEADBEEF));
      wait2();
      chk("wrongkey_single", 64'(out_single), 1);
      chk("wrongkey_syndrome", 64'(out_syndrome), 64'h03);
      @(negedge clk);
      chk("wrongkey_cnt", 64'(single_cnt), 2);
      tick();

      send(32'h0F0F_1234, enc(32'h0F0F_1234));
      send(32'h8000_0001, enc(32'h8000_0001));
      in_valid  = 1'b1;
      in_data   = 32'h5555_AAAA;
      in_chk    = enc(32'h5555_AAAA);
      key_start = 1'b1;
      @(negedge clk);
      chk("keystart_wins", 64'(in_ready), 0);
      tick();
      key_start = 1'b0;
      in_valid  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("drain_ready", 64'(in_ready), 0);
         tick();
      end
      chk("inflight_done", 64'(q.size()), 0);
      load_key(MASK);
      send(32'h1234_5678, enc(32'h1234_5678));
      wait2();
      chk("newkey_data", 64'(out_data), 64'h012345678);
      chk("newkey_single", 64'(out_single), 0);
      chk("newkey_double", 64'(out_double), 0);
      tick();

      base = n_out;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               d = 32'hA5A5_0000 + 32'(i) * 32'h1111;
               c = enc(d);
               if (i % 3 == 1) d[i] = ~d[i];
               if (i % 3 == 2) begin
                  d[i]     = ~d[i];
                  d[i + 8] = ~d[i + 8];
               end
               send(d, c);
            end
         end
         begin
            repeat (2) tick();
            out_ready = 1'b0;
            repeat (3) tick();
            out_ready = 1'b1;
         end
      join
      in_valid = 1'b0;
      drain("stream_drain");
      chk("stream_count", 64'(n_out - base), 8);

      key_start = 1'b1;
      tick();
      key_start = 1'b0;
      repeat (5) tick();
      key_start = 1'b1;
      tick();
      key_start = 1'b0;
      for (int i = KW - 1; i >= KW - 20; i--) begin
         key_valid = 1'b1;
         key_bit   = MASK[i];
         tick();
      end
      key_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("midrst_key_loaded", 64'(key_loaded), 0);
      chk("midrst_in_ready", 64'(in_ready), 0);
      chk("midrst_single_cnt", 64'(single_cnt), 0);
      chk("midrst_double_cnt", 64'(double_cnt), 0);
      chk("midrst_out_valid", 64'(out_valid), 0);
      @(negedge clk);
      tick();
      rst_n  = 1'b1;
      tb_key = '0;
      @(negedge clk);
      chk("post_rst_ready", 64'(in_ready), 0);
      tick();
      load_key(MASK);
      send(32'hCAFEF00D ^ 32'h8000_0000, enc(32'hCAFEF00D));
      wait2();
      chk("reload_single", 64'(out_single), 1);
      chk("reload_syndrome", 64'(out_syndrome), 64'h26);
      chk("reload_data", 64'(out_data), 64'h0CAFEF00D);
      @(negedge clk);
      chk("reload_cnt", 64'(single_cnt), 1);
      tick();
      drain("final_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/keyed_secded_decoder.md
Name: keyed_secded_decoder

Overview:
- Parametrised, pipelined, key-locked SEC-DED decoder. Successor to the team's combinational locked single-error-correcting benchmark circuits.
- Codeword inputs pass through XOR key gates driven by a serially loaded key register. Only the correct key reproduces the true codeword.
- A 2-stage pipeline computes syndrome, correction and error flags under valid/ready flow control.
- Serves as a sequential, scalable target for the deobfuscation flow.

Parameters:
- DATA_W, 32, data bits per codeword (8..64).
- CHK_W, 7, check bits: Hamming r (minimal r with 2^r >= DATA_W+r+1) plus 1 overall parity bit.
- KEY_W, DATA_W+CHK_W, key bits; one XOR key gate per codeword bit.
- LOCK_MASK, 39'h4D_2B3C_9E17, baked-in key-gate inversions; the correct key equals LOCK_MASK.
- CNT_W, 16, width of the error counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- key_start  in  1  request a key (re)load
- key_bit  in  1  serial key bit, MSB first
- key_valid  in  1  key_bit qualifier
- key_loaded  out  1  key register holds KEY_W fresh bits
- in_valid  in  1  codeword valid
- in_ready  out  1  decoder accepts a codeword
- in_data  in  DATA_W  received data bits
- in_chk  in  CHK_W  received check bits
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts the result
- out_data  out  DATA_W  corrected data
- out_syndrome  out  CHK_W-1  Hamming syndrome
- out_single  out  1  single error corrected
- out_double  out  1  uncorrectable double error
- single_cnt  out  CNT_W  saturating count of corrected codewords
- double_cnt  out  CNT_W  saturating count of double errors

Behaviour:
- Reset values:
  - FSM = LOCKED; key register = 0; key_loaded = 0; in_ready = 0.
  - Both pipeline valid bits = 0; all out_* = 0; both counters = 0.
- FSM states and transitions:
  - LOCKED: in_ready = 0. key_start -> LOAD.
  - LOAD: in_ready = 0. Each cycle with key_valid=1, key <= {key[KEY_W-2:0], key_bit} and the bit counter increments. When the KEY_W-th bit is accepted -> ACTIVE and key_loaded=1 on the next cycle. key_start during LOAD restarts the load: counter = 0, key is kept, still LOAD.
  - ACTIVE: in_ready = stage-1 empty or stage-1 advancing.
  - key_start in ACTIVE -> DRAIN: key_loaded=0, in_ready=0.
  - DRAIN -> LOAD in the first cycle both pipeline stages are empty.
- Key gates: cw = {in_chk, in_data} ^ key ^ LOCK_MASK. A wrong key corrupts cw silently; no flag is raised.
- Stage 1, on input handshake: register cw, Hamming syndrome (r bits) and overall parity of cw.
- Stage 2, classification:
  - syndrome=0 and parity=0: clean.
  - parity=1: single error. If syndrome is nonzero, flip the mapped data bit; if it maps to a check bit or is 0, data is unchanged.
  - syndrome!=0 and parity=0: double error; out_data = uncorrected data.
- Latency: exactly 2 cycles from input handshake to out_valid with no stall.
- Flow control:
  - Full throughput of 1 codeword per cycle.
  - out_valid && !out_ready holds every out_* stable; stage 1 holds when stage 2 is stalled.
  - No bubbles and no drops.
- Counters:
  - Increment on the output handshake when out_single or out_double is set, respectively.
  - Saturate at 2^CNT_W-1.
  - Unaffected by key reloads.
- Async reset mid-load or mid-stream: everything returns to reset values immediately; partial key bits are discarded.
- Simultaneous key_start and in_valid in ACTIVE: key_start wins; the codeword is not accepted (in_ready already low that cycle via combinational decode).

Decomposition:
- Package keyed_secded_pkg holds:
  - state enum {LOCKED, LOAD, ACTIVE, DRAIN};
  - function chk_bits(DATA_W);
  - function hamming_pos(i), mapping data index to codeword position;
  - function syn2idx(syn) plus a valid flag.
- Sub-module secded_syndrome: combinational syndrome and parity generation, parametrised on DATA_W. Reused by a future encoder.

Test Plan:
- Reset, then load key = LOCK_MASK over 39 cycles -> key_loaded rises the cycle after the 39th bit. Send data 32'hDEADBEEF with its correct check bits -> out_data=32'hDEADBEEF, out_single=0, out_double=0 two cycles later.
- Correct key, flip data bit 5 -> out_data restored, out_single=1, nonzero syndrome, single_cnt=1. Flip bits 5 and 17 -> out_double=1, double_cnt=1.
- Key with LOCK_MASK bit 0 inverted, clean codeword -> out_single=1 and a wrong result where expected clean. Proves the key gates are live.
- Stream 8 back-to-back codewords, out_ready low for cycles 3-5 -> all 8 outputs appear in order, values held while stalled, no loss.
- key_start asserted while 2 codewords are in flight -> both complete, in_ready stays 0 until reload finishes, then a new codeword decodes with the new key.
- rst_n pulsed low after 20 key bits -> key_loaded=0, FSM LOCKED, counters 0; a subsequent full reload works.
